// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle LOAD/STORE/MOV/MAC controller; define MC_CTRL_MEM_TIMEOUT_EN to add a MEM wait timeout
module mc_ctrl #(
  parameter int OPCODE_WIDTH = 3,
  parameter int MAC_CYCLES   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    mem_ready,
  output logic                    ir_we,
  output logic                    pc_en,
  output logic                    RegWEn,
  output logic                    MemWEn,
  output logic                    mem_req,
  output logic                    mac_en,
  output logic                    busy,
  output logic                    illegal,
  output logic                    timeout,
  output logic [2:0]              state
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    ERR    = 3'd7
  } state_t;
  localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_STORE = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_MOV   = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_MAC   = OPCODE_WIDTH'(4);
  state_t                  cur;
  state_t                  decNext;
  state_t                  endNext;
  logic [OPCODE_WIDTH-1:0] op_q;
  logic [3:0]              execCnt;
  logic                    isStore;
  logic                    memTimeout;
  assign isStore = op_q == OP_STORE;
  assign endNext = stop ? IDLE : FETCH;
  assign state   = cur;
  // route the live opcode to its first execution state; anything unlisted is illegal
  always_comb decNext = (opcode == OP_LOAD || opcode == OP_STORE) ? MEM :
                        opcode == OP_MOV ? WB :
                        opcode == OP_MAC ? EXEC : ERR;
`ifdef MC_CTRL_MEM_TIMEOUT_EN
  logic [4:0] memWait;
  assign memTimeout = cur == MEM && !mem_ready && memWait == 5'd15;
  // count cycles spent waiting in MEM; the timeout flag stays set until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      memWait <= 5'd0;
      timeout <= 1'b0;
    end else begin
      memWait <= cur == MEM ? memWait + 5'd1 : 5'd0;
      if (memTimeout) timeout <= 1'b1;
    end
  end
`else
  assign memTimeout = 1'b0;
  assign timeout    = 1'b0;
`endif
  // instruction sequencing: opcode latch, MAC cycle counter and sticky illegal flag
  always_ff @(posedge clk) begin
    if (rst) begin
      cur     <= IDLE;
      op_q    <= '0;
      execCnt <= 4'd0;
      illegal <= 1'b0;
    end else begin
      case (cur)
        IDLE:    cur <= start ? FETCH : IDLE;
        FETCH:   cur <= DECODE;
        DECODE: begin
          op_q    <= opcode;
          execCnt <= 4'd0;
          cur     <= decNext;
          if (decNext == ERR) illegal <= 1'b1;
        end
        EXEC: begin
          execCnt <= execCnt + 4'd1;
          if (execCnt == 4'(MAC_CYCLES - 1)) cur <= WB;
        end
        MEM:     cur <= mem_ready ? (isStore ? endNext : WB) : memTimeout ? ERR : MEM;
        WB:      cur <= endNext;
        ERR:     cur <= ERR;
        default: cur <= ERR;
      endcase
    end
  end
  // strobes decode from state and latched opcode; a store retires in the MEM cycle its access completes
  always_comb begin
    ir_we   = cur == FETCH;
    mac_en  = cur == EXEC;
    mem_req = cur == MEM;
    MemWEn  = cur == MEM && isStore;
    RegWEn  = cur == WB;
    pc_en   = cur == WB || (cur == MEM && isStore && mem_ready);
    busy    = cur != IDLE && cur != ERR;
  end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized instruction stream scored against a per-instruction latency/strobe model
module tb_mc_ctrl;
  localparam int MC = 4;
  logic       clk = 1'b0;
  logic       rst, start, stop, mem_ready;
  logic [2:0] opcode;
  logic       ir_we, pc_en, RegWEn, MemWEn, mem_req, mac_en, busy, illegal, timeout;
  logic [2:0] state;
  int nChk = 0, nPass = 0, cyc = 0;
  int nIr = 0, nMacS = 0, nMemS = 0;
  typedef struct {int at; int rw; int mw; int nMac; int nMem;} exp_t;
  exp_t sb[$];
  logic [2:0] legalOps [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
  logic [2:0] badOps   [4] = '{3'd3, 3'd5, 3'd6, 3'd7};

  mc_ctrl #(.OPCODE_WIDTH(3), .MAC_CYCLES(MC)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .opcode(opcode), .mem_ready(mem_ready),
    .ir_we(ir_we), .pc_en(pc_en), .RegWEn(RegWEn), .MemWEn(MemWEn), .mem_req(mem_req),
    .mac_en(mac_en), .busy(busy), .illegal(illegal), .timeout(timeout), .state(state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input int act, input int req);
    nChk++;
    if (act == req) nPass++;
    else $display("FAIL %s: got %0d expected %0d", n, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int outs();
    return int'({ir_we, pc_en, RegWEn, MemWEn, mem_req, mac_en, busy, illegal, timeout, state});
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      nIr = 0; nMacS = 0; nMemS = 0;
    end else begin
      if (RegWEn || MemWEn) chk("regwen_memwen_exclusive", int'(RegWEn && MemWEn), 0);
      nIr += int'(ir_we);
      nMacS += int'(mac_en);
      nMemS += int'(mem_req);
      if (pc_en) begin
        chk("pc_en_expected", int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("pc_en_cycle", cyc, e.at);
          chk("regwen_at_end", int'(RegWEn), e.rw);
          chk("memwen_at_end", int'(MemWEn), e.mw);
          chk("busy_at_end", int'(busy), 1);
          chk("ir_we_cycles", nIr, 1);
          chk("mac_en_cycles", nMacS, e.nMac);
          chk("mem_req_cycles", nMemS, e.nMem);
        end
        nIr = 0; nMacS = 0; nMemS = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before 500000");
    $fatal;
  end

  initial begin
    logic [2:0] op;
    int w, len;
    bit st, isMem, idle;
    rst = 1; start = 0; stop = 0; opcode = 0; mem_ready = 0;
    tick(); tick();
    chk("reset_outputs", outs(), 0);
    rst = 0;
    idle = 1;
    for (int i = 0; i < 40; i++) begin
      if (idle) begin
        repeat ($urandom_range(0, 2)) begin
          start = 0; stop = 1'($urandom); mem_ready = 1'($urandom); opcode = 3'($urandom);
          tick();
        end
        start = 1;
        tick();
      end
      op = legalOps[$urandom_range(0, 3)];
      w = $urandom_range(0, 3);
      st = $urandom_range(0, 3) == 0;
      isMem = op == 3'd0 || op == 3'd1;
      len = op == 3'd2 ? 3 : op == 3'd1 ? 3 + w : op == 3'd0 ? 4 + w : 3 + MC;
      sb.push_back('{cyc + len - 1, int'(op != 3'd1), int'(op == 3'd1), op == 3'd4 ? MC : 0, isMem ? w + 1 : 0});
      for (int c = 0; c < len; c++) begin
        opcode = c <= 1 ? op : 3'($urandom);
        start = 1'($urandom);
        stop = c == len - 1 ? st : 1'($urandom);
        mem_ready = (isMem && c >= 2 && c <= 2 + w) ? (c == 2 + w) : 1'($urandom);
        tick();
      end
      idle = st;
    end
    chk("scoreboard_drained", sb.size(), 0);
    start = 0; stop = 0; mem_ready = 0;
    rst = 1; tick();
    chk("reset_after_random", outs(), 0);
    rst = 0;
    opcode = badOps[$urandom_range(0, 3)];
    start = 1; tick(); start = 0; tick(); tick();
    chk("err_state", state, 7);
    chk("err_illegal", illegal, 1);
    chk("err_busy", busy, 0);
    chk("err_strobes", int'({ir_we, pc_en, RegWEn, MemWEn, mem_req, mac_en}), 0);
    start = 1; repeat (3) tick();
    chk("err_ignores_start", state, 7);
    start = 0;
    rst = 1; tick();
    chk("err_reset_illegal", illegal, 0);
    chk("err_reset_state", state, 0);
    rst = 0;
    opcode = 0; mem_ready = 0;
    start = 1; tick(); start = 0; tick(); tick();
    chk("load_mem_first", state, 4);
    tick();
    rst = 1; tick();
    chk("mid_mem_reset", outs(), 0);
    rst = 0;
    mem_ready = 1; repeat (4) tick();
    chk("mid_mem_stays_idle", outs(), 0);
    mem_ready = 0; opcode = 0;
    start = 1; tick(); start = 0; tick(); tick();
    repeat (15) tick();
    chk("timeout_mem16", state, 4);
    tick();
`ifdef MC_CTRL_MEM_TIMEOUT_EN
    chk("timeout_err_state", state, 7);
    chk("timeout_flag", timeout, 1);
    chk("timeout_busy", busy, 0);
`else
    repeat (83) tick();
    chk("no_timeout_state", state, 4);
    chk("no_timeout_flag", timeout, 0);
    chk("no_timeout_mem_req", mem_req, 1);
`endif
    rst = 1; tick();
    chk("timeout_reset", outs(), 0);
    rst = 0;
    chk("scoreboard_final", sb.size(), 0);
    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end
endmodule
